game_map_responder: RTL and testbench

- Owns the 40x30 tile map RAM that holds 8-bit sprite codes.
- Responds to the game controller's get/update request interface: posx, posy, sprite, update, get, ready and read_sprite.
- Also serves per-tile reads for the display pipeline. The display always has priority on the single RAM port.
- Exports busy so the controller can tell when its requests are stalled.

---
 rtl/game_map_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_game_map_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_map_responder.sv
// 40x30 tile map RAM shared between the game controller (get/update handshake) and the display.
// The display always owns the single RAM port. Define GAME_MAP_CLEAR_EN to sweep the map to CLEAR_TILE after reset.
module game_map_responder #(
    parameter int unsigned MAP_W      = 40,
    parameter int unsigned MAP_H      = 30,
    parameter int unsigned ADDR_W     = 11,
    parameter logic [7:0]  CLEAR_TILE = 8'd0
) (
    input  logic       px_clk,
    input  logic       rst_n,
    input  logic [5:0] posx,
    input  logic [5:0] posy,
    input  logic [7:0] sprite,
    input  logic       update,
    input  logic       get,
    output logic [7:0] read_sprite,
    output logic       ready,
    output logic       busy,
    input  logic       disp_req,
    input  logic [5:0] disp_x,
    input  logic [5:0] disp_y,
    output logic [7:0] disp_tile,
    output logic       disp_valid
);

    localparam logic [6:0]        MAP_W7 = 7'(MAP_W);
    localparam logic [6:0]        MAP_H7 = 7'(MAP_H);
    localparam logic [ADDR_W-1:0] MAP_WA = ADDR_W'(MAP_W);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        RD_DONE
`ifdef GAME_MAP_CLEAR_EN
        , CLEAR
`endif
    } state_t;

`ifdef GAME_MAP_CLEAR_EN
    localparam state_t            RESET_STATE = CLEAR;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(MAP_W * MAP_H - 1);
    logic [ADDR_W-1:0] clr_addr;
`else
    localparam state_t            RESET_STATE = IDLE;
`endif

    function automatic logic in_map(input logic [5:0] x, input logic [5:0] y);
        return ({1'b0, x} < MAP_W7) && ({1'b0, y} < MAP_H7);
    endfunction

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [5:0] x, input logic [5:0] y);
        logic [ADDR_W-1:0] ya;
        logic [ADDR_W-1:0] xa;
        ya = ADDR_W'(y);
        xa = ADDR_W'(x);
        if (MAP_W == 40)
            return (ya << 5) + (ya << 3) + xa;
        return ya * MAP_WA + xa;
    endfunction

    state_t            state;
    logic              upd_q;
    logic              wr_pend;
    logic [5:0]        wr_x;
    logic [5:0]        wr_y;
    logic [7:0]        wr_data;
    logic              rd_pend;
    logic [5:0]        rd_x;
    logic [5:0]        rd_y;
    logic              disp_clr_q;
    logic [7:0]        ram_q;
    logic [7:0]        mem [2**ADDR_W];

    logic              upd_edge;
    logic              wr_ok;
    logic              rd_ok;
    logic              disp_ok;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;

    assign upd_edge = update & ~upd_q;
    assign wr_ok    = in_map(wr_x, wr_y);
    assign rd_ok    = in_map(rd_x, rd_y);
    assign disp_ok  = in_map(disp_x, disp_y);

    // Out-of-range requests never touch the RAM; their data is substituted downstream.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = tile_addr(wr_x, wr_y);
        ram_wdata = wr_data;
        if (disp_req) begin
            ram_addr = tile_addr(disp_x, disp_y);
            ram_re   = disp_ok;
        end else begin
            case (state)
                WR: ram_we = wr_ok;
                RD_ISSUE: begin
                    ram_addr = tile_addr(rd_x, rd_y);
                    ram_re   = rd_ok;
                end
`ifdef GAME_MAP_CLEAR_EN
                CLEAR: begin
                    ram_we    = 1'b1;
                    ram_addr  = clr_addr;
                    ram_wdata = CLEAR_TILE;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge px_clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        if (ram_re)
            ram_q <= mem[ram_addr];
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RESET_STATE;
            upd_q       <= 1'b0;
            wr_pend     <= 1'b0;
            wr_x        <= '0;
            wr_y        <= '0;
            wr_data     <= '0;
            rd_pend     <= 1'b0;
            rd_x        <= '0;
            rd_y        <= '0;
            read_sprite <= '0;
            ready       <= 1'b0;
            disp_valid  <= 1'b0;
            disp_clr_q  <= 1'b0;
`ifdef GAME_MAP_CLEAR_EN
            clr_addr    <= '0;
`endif
        end else begin
            upd_q      <= update;
            disp_valid <= disp_req;
`ifdef GAME_MAP_CLEAR_EN
            disp_clr_q <= !disp_ok || (state == CLEAR);
`else
            disp_clr_q <= !disp_ok;
`endif
            case (state)
                // A get arriving with no write outstanding goes straight to issue, giving the 3-cycle latency.
                IDLE: begin
                    if (get) begin
                        rd_pend <= 1'b1;
                        rd_x    <= posx;
                        rd_y    <= posy;
                    end
                    if (!disp_req) begin
                        if (wr_pend || upd_edge) begin
                            state <= WR;
                        end else if (rd_pend || get) begin
                            rd_pend <= 1'b0;
                            state   <= RD_ISSUE;
                        end
                    end
                end
                WR: begin
                    if (!disp_req) begin
                        wr_pend <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RD_ISSUE: begin
                    if (!disp_req)
                        state <= RD_WAIT;
                end
                RD_WAIT: begin
                    read_sprite <= rd_ok ? ram_q : CLEAR_TILE;
                    ready       <= 1'b1;
                    state       <= RD_DONE;
                end
                RD_DONE: begin
                    if (!get) begin
                        ready <= 1'b0;
                        state <= IDLE;
                    end
                end
`ifdef GAME_MAP_CLEAR_EN
                CLEAR: begin
                    if (get) begin
                        rd_pend <= 1'b1;
                        rd_x    <= posx;
                        rd_y    <= posy;
                    end
                    if (!disp_req) begin
                        clr_addr <= clr_addr + 1'b1;
                        if (clr_addr == LAST_ADDR)
                            state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
            // Placed after the case so a fresh edge in the commit cycle re-arms the pending write.
            if (upd_edge) begin
                wr_pend <= 1'b1;
                wr_x    <= posx;
                wr_y    <= posy;
                wr_data <= sprite;
            end
        end
    end

`ifdef GAME_MAP_CLEAR_EN
    assign busy = rst_n & (disp_req | (state == CLEAR));
`else
    assign busy = rst_n & disp_req;
`endif

    assign disp_tile = disp_valid ? (disp_clr_q ? CLEAR_TILE : ram_q) : '0;

endmodule

// File: tb/tb_game_map_responder.sv
// Directed bench for game_map_responder: tile-map model plus per-cycle display/busy checker.
module tb_game_map_responder;

    logic       px_clk = 1'b0;
    logic       rst_n  = 1'b0;
    logic [5:0] posx = '0, posy = '0, disp_x = '0, disp_y = '0;
    logic [7:0] sprite = '0;
    logic       update = 1'b0, get = 1'b0, disp_req = 1'b0;
    logic [7:0] read_sprite, disp_tile;
    logic       ready, busy, disp_valid;

    int checks = 0;
    int passes = 0;

    logic [7:0] m_mem   [64][64];
    bit         m_known [64][64];
    bit         in_clear = 1'b0;

    always #5 px_clk = ~px_clk;

    game_map_responder #(.MAP_W(40), .MAP_H(30), .ADDR_W(11), .CLEAR_TILE(8'd0)) dut (
        .px_clk(px_clk), .rst_n(rst_n), .posx(posx), .posy(posy), .sprite(sprite),
        .update(update), .get(get), .read_sprite(read_sprite), .ready(ready), .busy(busy),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
        .disp_tile(disp_tile), .disp_valid(disp_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit m_oor(input int x, input int y);
        return (x >= 40) || (y >= 30);
    endfunction

    function automatic logic [7:0] m_tile(input int x, input int y);
        return m_oor(x, y) ? 8'h00 : m_mem[x][y];
    endfunction

    function automatic bit m_is_known(input int x, input int y);
        return m_oor(x, y) || m_known[x][y];
    endfunction

    // Display model: a request seen at an edge must be answered in the next cycle.
    logic       d_pend = 1'b0;
    bit         d_known = 1'b0;
    logic [7:0] d_exp = '0;

    always @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            d_pend <= 1'b0;
        end else begin
            d_pend  <= disp_req;
            d_known <= in_clear || m_is_known(disp_x, disp_y);
            d_exp   <= in_clear ? 8'h00 : m_tile(disp_x, disp_y);
        end
    end

    always @(negedge px_clk) begin
        if (rst_n) begin
            if (!in_clear) check("busy", busy, disp_req);
            check("disp_valid", disp_valid, d_pend);
            if (d_pend && d_known) check("disp_tile", disp_tile, d_exp);
        end
    end

    task automatic after_reset();
`ifdef GAME_MAP_CLEAR_EN
        int n = 0;
        in_clear = 1'b1;
        @(negedge px_clk);
        while (busy === 1'b1 && n < 5000) begin
            n++;
            @(negedge px_clk);
        end
        check("clear_cycles", n, 1200);
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 64; y++) begin
                m_mem[x][y]   = 8'h00;
                m_known[x][y] = 1'b1;
            end
        in_clear = 1'b0;
`endif
        repeat (2) @(posedge px_clk);
    endtask

    task automatic wr(input int x, input int y, input logic [7:0] d);
        @(posedge px_clk); #1;
        posx = 6'(x); posy = 6'(y); sprite = d; update = 1'b1;
        if (!m_oor(x, y)) begin m_mem[x][y] = d; m_known[x][y] = 1'b1; end
        @(posedge px_clk); #1;
        update = 1'b0;
        repeat (2) @(posedge px_clk);
    endtask

    // get rises in cycle N; ready is due in cycle N+3+stall, with the display held for the first stall cycles.
    task automatic rd(input string name, input int x, input int y, input int stall, input logic [7:0] exp);
        @(posedge px_clk); #1;
        posx = 6'(x); posy = 6'(y); get = 1'b1;
        if (stall > 0) begin disp_req = 1'b1; disp_x = 6'd10; disp_y = 6'd10; end
        for (int k = 0; k <= 3 + stall; k++) begin
            @(negedge px_clk);
            if (k < 3 + stall) begin
                check({name, "_ready_early"}, ready, 1'b0);
                @(posedge px_clk); #1;
                if (k + 1 == stall) disp_req = 1'b0;
            end else begin
                check({name, "_ready"}, ready, 1'b1);
                check({name, "_data"}, read_sprite, exp);
            end
        end
        @(posedge px_clk); #1;
        get = 1'b0;
        @(negedge px_clk);
        check({name, "_ready_hold"}, ready, 1'b1);
        @(negedge px_clk);
        check({name, "_ready_drop"}, ready, 1'b0);
    endtask

    task automatic disp_rd(input string name, input int x, input int y, input logic [7:0] exp);
        @(posedge px_clk); #1;
        disp_req = 1'b1; disp_x = 6'(x); disp_y = 6'(y);
        @(posedge px_clk); #1;
        disp_req = 1'b0;
        @(negedge px_clk);
        check(name, disp_tile, exp);
    endtask

    initial begin
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 64; y++) begin
                m_mem[x][y]   = 8'h00;
                m_known[x][y] = 1'b0;
            end

        #1;
        check("rst_read_sprite", read_sprite, 8'h00);
        check("rst_ready", ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_disp_tile", disp_tile, 8'h00);
        check("rst_disp_valid", disp_valid, 1'b0);
        repeat (3) @(posedge px_clk);
        #1 rst_n = 1'b1;
        after_reset();

        wr(10, 10, 8'h07);
        rd("wr_rd", 10, 10, 0, 8'h07);

        wr(11, 10, 8'h5C);
        rd("disp_stall", 11, 10, 5, 8'h5C);

        wr(5, 0, 8'h50);
        wr(0, 6, 8'h66);
        wr(39, 5, 8'h39);
        wr(40, 5, 8'h33);
        rd("oor_x", 40, 5, 0, 8'h00);
        rd("oor_y", 3, 30, 0, 8'h00);
        disp_rd("oor_nb_0_6", 0, 6, 8'h66);
        disp_rd("oor_nb_5_0", 5, 0, 8'h50);
        disp_rd("oor_nb_39_5", 39, 5, 8'h39);
        disp_rd("oor_disp", 63, 63, 8'h00);

        // Two writes to one tile plus a read, all queued behind a held display request.
        begin
            int n = 0;
            @(posedge px_clk); #1;
            disp_req = 1'b1; disp_x = 6'd10; disp_y = 6'd10;
            posx = 6'd3; posy = 6'd3; sprite = 8'h01; update = 1'b1;
            m_mem[3][3] = 8'h01; m_known[3][3] = 1'b1;
            @(posedge px_clk); #1;
            update = 1'b0;
            @(posedge px_clk); #1;
            sprite = 8'h02; update = 1'b1; get = 1'b1;
            m_mem[3][3] = 8'h02;
            @(posedge px_clk); #1;
            update = 1'b0;
            @(posedge px_clk); #1;
            disp_req = 1'b0;
            @(negedge px_clk);
            while (ready !== 1'b1 && n < 40) begin
                n++;
                @(negedge px_clk);
            end
            check("coalesce_ready", ready, 1'b1);
            check("coalesce_data", read_sprite, 8'h02);
            @(posedge px_clk); #1;
            get = 1'b0;
            repeat (2) @(posedge px_clk);
        end

        for (int x = 0; x < 20; x++) wr(x, 2, 8'hA0 + 8'(x));
        @(posedge px_clk); #1;
        posy = 6'd2; update = 1'b1;
        for (int x = 0; x < 20; x++) begin
            posx = 6'(x); sprite = 8'h60 + 8'(x);
            if (x == 0) m_mem[0][2] = 8'h60;
            @(posedge px_clk); #1;
        end
        update = 1'b0;
        repeat (3) @(posedge px_clk);
        disp_rd("level_x0", 0, 2, 8'h60);
        disp_rd("level_x1", 1, 2, 8'hA1);
        for (int x = 2; x < 20; x++) disp_rd("level_row", x, 2, m_tile(x, 2));

        // Abort a read while it sits in RD_WAIT; reset is held across an edge where ready would rise.
        wr(20, 20, 8'hC3);
        @(posedge px_clk); #1;
        posx = 6'd20; posy = 6'd20; get = 1'b1;
        repeat (2) @(posedge px_clk);
        @(negedge px_clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", ready, 1'b0);
        @(posedge px_clk); #1;
        check("rst_mid_ready_edge", ready, 1'b0);
        check("rst_mid_sprite", read_sprite, 8'h00);
        get = 1'b0;
        @(posedge px_clk); #1;
        rst_n = 1'b1;
        after_reset();
        check("post_rst_ready", ready, 1'b0);
        rd("post_rst", 20, 20, 0, m_tile(20, 20));
        disp_rd("post_rst_disp", 10, 10, m_tile(10, 10));

        repeat (3) @(posedge px_clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
